mult_share_sched: RTL

Two-requester scheduler that time-shares one combined multiplier array (two packed 19x18 products in mode 0, one 27x27 product in mode 1) between requester ports 0 and 1. When both requesters present 19x18 ops in the same cycle, it pairs them into one mode-0 issue. Otherwise it issues one op per cycle under round-robin priority. It registers the array inputs, captures the array output one cycle later, and routes each product back to its requester. It sits between the MAC front-end issue logic and the multiplier array.

---
 rtl/mul_sched_pkg.sv | 16 +
 rtl/mult_share_sched_if.sv | 25 ++
 rtl/mul_sched_arb.sv | 47 ++++
 rtl/mult_share_sched.sv | 129 ++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// rtl/mul_sched_pkg.sv - shared op encodings, lane widths and lane packing helper
package mul_sched_pkg;
  localparam logic OP_19X18 = 1'b0;
  localparam logic OP_27X27 = 1'b1;

  localparam int A19 = 19;
  localparam int B18 = 18;
  localparam int P37 = 37;
  localparam int W27 = 27;
  localparam int P54 = 54;

  // One mode-0 lane: B operand in the upper 18 bits, A operand in the lower 19.
  function automatic logic [P37-1:0] pack_lane(input logic [W27-1:0] a, input logic [W27-1:0] b);
    return {b[B18-1:0], a[A19-1:0]};
  endfunction
endpackage

// File: rtl/mult_share_sched_if.sv
// rtl/mult_share_sched_if.sv - requester request/response bundle
interface mult_share_sched_if;
  import mul_sched_pkg::*;

  logic [1:0]     req_valid;
  logic [1:0]     req_ready;
  logic [1:0]     req_op;
  logic [W27-1:0] req_a0;
  logic [W27-1:0] req_a1;
  logic [W27-1:0] req_b0;
  logic [W27-1:0] req_b1;
  logic [1:0]     rsp_valid;
  logic [P54-1:0] rsp_data0;
  logic [P54-1:0] rsp_data1;

  modport master (
    output req_valid, req_op, req_a0, req_a1, req_b0, req_b1,
    input  req_ready, rsp_valid, rsp_data0, rsp_data1
  );

  modport slave (
    input  req_valid, req_op, req_a0, req_a1, req_b0, req_b1,
    output req_ready, rsp_valid, rsp_data0, rsp_data1
  );
endinterface

// File: rtl/mul_sched_arb.sv
// rtl/mul_sched_arb.sv - grant selection over the two holding registers plus round-robin pointer
module mul_sched_arb
  import mul_sched_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] hold_v,
  input  logic [1:0] op,
  output logic [1:0] grant,
  output logic       mode
);
  logic rr_q, rr_d;

  always_comb begin
    grant = 2'b00;
    mode  = OP_19X18;
    rr_d  = rr_q;
    case (hold_v)
      2'b01: begin
        grant = 2'b01;
        mode  = op[0];
        rr_d  = 1'b1;
      end
      2'b10: begin
        grant = 2'b10;
        mode  = op[1];
        rr_d  = 1'b0;
      end
      2'b11: begin
        // Two small ops share one mode-0 issue without disturbing fairness.
        if (op == {OP_19X18, OP_19X18}) begin
          grant = 2'b11;
        end else begin
          grant = rr_q ? 2'b10 : 2'b01;
          mode  = op[rr_q];
          rr_d  = ~rr_q;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) rr_q <= 1'b0;
    else        rr_q <= rr_d;
  end
endmodule

// File: rtl/mult_share_sched.sv
// rtl/mult_share_sched.sv - two-requester scheduler time-sharing one packed 19x18 / 27x27 multiplier array
module mult_share_sched
  import mul_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  mult_share_sched_if.slave   rq,
  output logic [P37-1:0]      MUL_IN1,
  output logic [P37-1:0]      MUL_IN2,
  output logic                MUL_MODE,
  input  logic [2*P37-1:0]    MUL_OUT
);
  logic [1:0]            hold_v_q, hold_v_d;
  logic [1:0]            hold_op_q, hold_op_d;
  logic [1:0][W27-1:0]   hold_a_q, hold_a_d;
  logic [1:0][W27-1:0]   hold_b_q, hold_b_d;
  logic [1:0]            iss_v_q, iss_v_d;
  logic                  iss_mode_q, iss_mode_d;
  logic [P37-1:0]        mul_in1_q, mul_in1_d;
  logic [P37-1:0]        mul_in2_q, mul_in2_d;
  logic [1:0]            rsp_valid_q, rsp_valid_d;
  logic [P54-1:0]        rsp_data0_q, rsp_data0_d;
  logic [P54-1:0]        rsp_data1_q, rsp_data1_d;

  logic [1:0]            grant;
  logic                  mode;
  logic [1:0]            ready;
  logic [1:0]            accept;
  logic [1:0][W27-1:0]   in_a, in_b;
  logic                  sel;

  mul_sched_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .hold_v (hold_v_q),
    .op     (hold_op_q),
    .grant  (grant),
    .mode   (mode)
  );

  assign in_a = {rq.req_a1, rq.req_a0};
  assign in_b = {rq.req_b1, rq.req_b0};

  // Ready comes only from registered state so requesters never see a valid->ready loop.
  assign ready  = ~hold_v_q | grant;
  assign accept = rq.req_valid & ready;

  always_comb begin
    hold_v_d  = hold_v_q;
    hold_op_d = hold_op_q;
    hold_a_d  = hold_a_q;
    hold_b_d  = hold_b_q;
    for (int i = 0; i < 2; i++) begin
      hold_v_d[i] = accept[i] | (hold_v_q[i] & ~grant[i]);
      if (accept[i]) begin
        hold_op_d[i] = rq.req_op[i];
        hold_a_d[i]  = in_a[i];
        hold_b_d[i]  = in_b[i];
      end
    end
  end

  always_comb begin
    iss_v_d    = grant;
    iss_mode_d = iss_mode_q;
    mul_in1_d  = mul_in1_q;
    mul_in2_d  = mul_in2_q;
    sel        = grant[1];
    if (|grant) begin
      iss_mode_d = mode;
      if (mode == OP_19X18) begin
        mul_in1_d = grant[0] ? pack_lane(hold_a_q[0], hold_b_q[0]) : '0;
        mul_in2_d = grant[1] ? pack_lane(hold_a_q[1], hold_b_q[1]) : '0;
      end else begin
        mul_in1_d = {10'b0, hold_a_q[sel]};
        mul_in2_d = {10'b0, hold_b_q[sel]};
      end
    end
  end

  always_comb begin
    rsp_valid_d = iss_v_q;
    rsp_data0_d = rsp_data0_q;
    rsp_data1_d = rsp_data1_q;
    if (iss_mode_q == OP_19X18) begin
      if (iss_v_q[0]) rsp_data0_d = {17'b0, MUL_OUT[P37-1:0]};
      if (iss_v_q[1]) rsp_data1_d = {17'b0, MUL_OUT[2*P37-1:P37]};
    end else begin
      if (iss_v_q[0]) rsp_data0_d = MUL_OUT[P54-1:0];
      if (iss_v_q[1]) rsp_data1_d = MUL_OUT[P54-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_v_q    <= '0;
      hold_op_q   <= '0;
      hold_a_q    <= '0;
      hold_b_q    <= '0;
      iss_v_q     <= '0;
      iss_mode_q  <= OP_19X18;
      mul_in1_q   <= '0;
      mul_in2_q   <= '0;
      rsp_valid_q <= '0;
      rsp_data0_q <= '0;
      rsp_data1_q <= '0;
    end else begin
      hold_v_q    <= hold_v_d;
      hold_op_q   <= hold_op_d;
      hold_a_q    <= hold_a_d;
      hold_b_q    <= hold_b_d;
      iss_v_q     <= iss_v_d;
      iss_mode_q  <= iss_mode_d;
      mul_in1_q   <= mul_in1_d;
      mul_in2_q   <= mul_in2_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data0_q <= rsp_data0_d;
      rsp_data1_q <= rsp_data1_d;
    end
  end

  assign rq.req_ready = ready;
  assign rq.rsp_valid = rsp_valid_q;
  assign rq.rsp_data0 = rsp_data0_q;
  assign rq.rsp_data1 = rsp_data1_q;
  assign MUL_IN1      = mul_in1_q;
  assign MUL_IN2      = mul_in2_q;
  assign MUL_MODE     = iss_mode_q;
endmodule
